// File: rtl/instr_encoder_if.sv
// Request channel of the instruction encoder: valid/ready handshake plus the
// symbolic instruction fields. master = request producer, slave = encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder/loader. Accepts symbolic requests, encodes
// LW/SW/R-type/ADDI/BEQ/J words and writes them to consecutive imem addresses.
// Optional NOP padding of the remaining memory is enabled with ENC_NOP_PAD_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef ENC_NOP_PAD_EN
  input  logic              pad,
`endif
  instr_encoder_if.slave    req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  localparam int unsigned       Cap      = 2 ** ADDR_W - BASE_ADDR;
  localparam logic [ADDR_W:0]   LastCnt  = (ADDR_W + 1)'(Cap - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

`ifdef ENC_NOP_PAD_EN
  typedef enum logic [1:0] {StIdle, StFull, StPad} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFull} state_e;
`endif

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic              accept;
  logic              legal;
  logic [31:0]       word;
  logic [ADDR_W:0]   issued;

  assign req.in_ready = (state_q == StIdle) & ~start;
  assign accept       = req.in_valid & req.in_ready;
  assign legal        = (req.op_sel <= 3'd5);
  // Words committed since start, including the one currently being written.
  assign issued       = count_q + (ADDR_W + 1)'(we_q);

  // Assemble the instruction word from the request fields.
  always_comb begin
    word = '0;
    case (req.op_sel)
      3'd0:    word = {6'b100011, req.rs, req.rt, req.imm};
      3'd1:    word = {6'b101011, req.rs, req.rt, req.imm};
      3'd2:    word = {6'b000000, req.rs, req.rt, req.rd, req.shamt, req.funct};
      3'd3:    word = {6'b001000, req.rs, req.rt, req.imm};
      3'd4:    word = {6'b000100, req.rs, req.rt, req.imm};
      3'd5:    word = {6'b000010, req.target};
      default: word = '0;
    endcase
  end

  // Next-state: write pointer/count bookkeeping, handshake and FSM.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;

    // A write in flight always completes; the pointer holds on the last slot.
    if (we_q) begin
      count_d = count_q + (ADDR_W + 1)'(1);
      if (count_q == LastCnt) begin
        full_d = 1'b1;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end

    if (start) begin
      state_d = StIdle;
      ptr_d   = BaseAddr;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (legal) begin
              we_d    = 1'b1;
              wdata_d = word;
              // Stop accepting once the last free slot has been claimed.
              if (issued == LastCnt) state_d = StFull;
            end else begin
              err_d = 1'b1;
            end
          end
`ifdef ENC_NOP_PAD_EN
          if (pad && (state_d == StIdle)) state_d = StPad;
`endif
        end
`ifdef ENC_NOP_PAD_EN
        StPad: begin
          we_d    = 1'b1;
          wdata_d = '0;
          if (issued == LastCnt) state_d = StFull;
        end
`endif
        StFull:  ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers; async reset aborts any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ptr_q   <= BaseAddr;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = ptr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (ADDR_W=6 and ADDR_W=2) driven by the
// same directed stimulus, a per-cycle behavioural model, and literal checks.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  op_sel = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic [1:0]       ready_a, we_a, full_a, err_a;
  logic [1:0][5:0]  addr_a;
  logic [1:0][31:0] wdata_a;
  logic [1:0][6:0]  count_a;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned AW = (g == 0) ? 6 : 2;
    instr_encoder_if bus ();
    logic          we, full, err;
    logic [AW-1:0] addr;
    logic [AW:0]   cnt;
    logic [31:0]   wdata;

    assign bus.in_valid = in_valid;
    assign bus.op_sel   = op_sel;
    assign bus.rs       = rs;
    assign bus.rt       = rt;
    assign bus.rd       = rd;
    assign bus.shamt    = shamt;
    assign bus.funct    = funct;
    assign bus.imm      = imm;
    assign bus.target   = target;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
`ifdef ENC_NOP_PAD_EN
      .pad         (1'b0),
`endif
      .req         (bus),
      .imem_we     (we),
      .imem_addr   (addr),
      .imem_wdata  (wdata),
      .count       (cnt),
      .full        (full),
      .err_illegal (err)
    );

    assign ready_a[g] = bus.in_ready;
    assign we_a[g]    = we;
    assign full_a[g]  = full;
    assign err_a[g]   = err;
    assign addr_a[g]  = 6'(addr);
    assign wdata_a[g] = wdata;
    assign count_a[g] = 7'(cnt);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoding straight from the MIPS field layouts.
  function automatic logic [31:0] enc(input logic [2:0] op);
    case (op)
      3'd0:    return {6'd35, rs, rt, imm};
      3'd1:    return {6'd43, rs, rt, imm};
      3'd2:    return {6'd0, rs, rt, rd, shamt, funct};
      3'd3:    return {6'd8, rs, rt, imm};
      3'd4:    return {6'd4, rs, rt, imm};
      default: return {6'd2, target};
    endcase
  endfunction

  // Model: a request is taken whenever fewer than capacity words were claimed.
  int          m_count [2];
  int          m_acc   [2];
  bit          m_we    [2];
  bit          m_err   [2];
  logic [31:0] m_wdata [2];

  function automatic int cap(input int i);
    return (i == 0) ? 64 : 4;
  endfunction

  function automatic bit exp_ready(input int i);
    return !start && (m_acc[i] < cap(i));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_count[i] <= 0;
        m_acc[i]   <= 0;
        m_we[i]    <= 1'b0;
        m_err[i]   <= 1'b0;
        m_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start) begin
          m_count[i] <= 0;
          m_acc[i]   <= 0;
          m_err[i]   <= 1'b0;
          m_we[i]    <= 1'b0;
        end else begin
          if (m_we[i]) m_count[i] <= m_count[i] + 1;
          if (in_valid && exp_ready(i)) begin
            if (op_sel <= 3'd5) begin
              m_we[i]    <= 1'b1;
              m_wdata[i] <= enc(op_sel);
              m_acc[i]   <= m_acc[i] + 1;
            end else begin
              m_we[i]  <= 1'b0;
              m_err[i] <= 1'b1;
            end
          end else begin
            m_we[i] <= 1'b0;
          end
        end
      end
    end
  end

  typedef struct {int addr; logic [31:0] data; int cyc;} wr_t;
  wr_t log0[$];
  wr_t log1[$];

  // Per-cycle comparison against the model, plus write logging.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d in_ready", i), 64'(ready_a[i]), 64'(exp_ready(i)));
        check($sformatf("u%0d imem_we", i), 64'(we_a[i]), 64'(m_we[i]));
        check($sformatf("u%0d count", i), 64'(count_a[i]), 64'(m_count[i]));
        check($sformatf("u%0d full", i), 64'(full_a[i]), 64'(m_count[i] == cap(i)));
        check($sformatf("u%0d err_illegal", i), 64'(err_a[i]), 64'(m_err[i]));
        if (m_we[i]) begin
          check($sformatf("u%0d imem_addr", i), 64'(addr_a[i]), 64'(m_count[i]));
          check($sformatf("u%0d imem_wdata", i), 64'(wdata_a[i]), 64'(m_wdata[i]));
        end
      end
      if (we_a[0]) log0.push_back('{int'(addr_a[0]), wdata_a[0], cyc});
      if (we_a[1]) log1.push_back('{int'(addr_a[1]), wdata_a[1], cyc});
    end
  end

  task automatic drive(input bit st, input bit v, input logic [2:0] op,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
    @(negedge clk);
    #1;
    start = st; in_valid = v; op_sel = op;
    rs = a; rt = b; rd = c; shamt = '0; funct = fn; imm = im; target = tg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
  endtask

  task automatic strt();
    drive(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
  endtask

  task automatic req_i(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [15:0] im);
    drive(1'b0, 1'b1, op, a, b, 5'd0, 6'd0, im, 26'd0);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst imem_we", 64'(we_a[0]), 64'd0);
    check("rst imem_addr", 64'(addr_a[0]), 64'd0);
    check("rst imem_wdata", 64'(wdata_a[0]), 64'd0);
    check("rst count", 64'(count_a[0]), 64'd0);
    check("rst full/err", 64'({full_a[0], err_a[0]}), 64'd0);
    #10 rst_n = 1'b1;

    // Single LW
    req_i(3'd0, 5'd1, 5'd2, 16'h0004);
    idle(); idle();
    check("lw writes", 64'(log0.size()), 64'd1);
    if (log0.size() == 1) begin
      check("lw addr", 64'(log0[0].addr), 64'd0);
      check("lw wdata", 64'(log0[0].data), 64'h8C220004);
    end
    check("lw count", 64'(count_a[0]), 64'd1);

    // Back-to-back R-type, BEQ, J
    strt(); log0.delete(); log1.delete();
    drive(1'b0, 1'b1, 3'd2, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
    req_i(3'd4, 5'd4, 5'd5, 16'hFFFF);
    drive(1'b0, 1'b1, 3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010);
    idle(); idle();
    check("b2b writes", 64'(log0.size()), 64'd3);
    if (log0.size() == 3) begin
      check("b2b addr0", 64'(log0[0].addr), 64'd0);
      check("b2b addr1", 64'(log0[1].addr), 64'd1);
      check("b2b addr2", 64'(log0[2].addr), 64'd2);
      check("b2b rtype", 64'(log0[0].data), 64'h00221820);
      check("b2b beq", 64'(log0[1].data), 64'h1085FFFF);
      check("b2b j", 64'(log0[2].data), 64'h08000010);
      check("b2b consecutive", 64'(log0[2].cyc - log0[0].cyc), 64'd2);
    end

    // Fill the ADDR_W=2 instance; fifth request must be refused
    strt(); log0.delete(); log1.delete();
    for (int k = 0; k < 5; k++) req_i(3'd1, 5'd1, 5'd2, 16'h0008);
    idle(); idle();
    check("fill writes small", 64'(log1.size()), 64'd4);
    for (int k = 0; k < 4 && k < log1.size(); k++) begin
      check("fill addr", 64'(log1[k].addr), 64'(k));
      check("fill sw word", 64'(log1[k].data), 64'hAC220008);
    end
    check("fill full", 64'(full_a[1]), 64'd1);
    check("fill in_ready", 64'(ready_a[1]), 64'd0);
    check("fill count", 64'(count_a[1]), 64'd4);
    check("fill addr holds", 64'(addr_a[1]), 64'd3);
    check("fill writes big", 64'(log0.size()), 64'd5);

    // Illegal op between two ADDIs
    strt(); log0.delete(); log1.delete();
    req_i(3'd3, 5'd1, 5'd2, 16'h0005);
    req_i(3'd7, 5'd9, 5'd9, 16'h1234);
    req_i(3'd3, 5'd3, 5'd4, 16'hFFFE);
    idle(); idle();
    check("illegal writes", 64'(log0.size()), 64'd2);
    if (log0.size() == 2) begin
      check("illegal addr1", 64'(log0[1].addr), 64'd1);
      check("illegal addi0", 64'(log0[0].data), 64'h20220005);
      check("illegal addi1", 64'(log0[1].data), 64'h2064FFFE);
    end
    check("illegal err", 64'(err_a[0]), 64'd1);
    check("illegal count", 64'(count_a[0]), 64'd2);
    strt(); idle();
    check("start clears err", 64'(err_a[0]), 64'd0);
    check("start clears count", 64'(count_a[0]), 64'd0);

    // start with in_valid, while a write is still in flight
    strt(); log0.delete();
    req_i(3'd3, 5'd1, 5'd2, 16'h0005);
    drive(1'b1, 1'b1, 3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010);
    check("inflight write", 64'(log0.size()), 64'd1);
    log0.delete();
    idle();
    req_i(3'd0, 5'd1, 5'd2, 16'h0004);
    idle(); idle();
    check("start+valid writes", 64'(log0.size()), 64'd1);
    if (log0.size() == 1) begin
      check("start+valid addr", 64'(log0[0].addr), 64'd0);
      check("start+valid wdata", 64'(log0[0].data), 64'h8C220004);
    end

    // Reset during an active write
    strt(); log0.delete();
    req_i(3'd0, 5'd1, 5'd2, 16'h0004);
    req_i(3'd0, 5'd1, 5'd2, 16'h0004);
    @(posedge clk);
    #2;
    check("pre-reset we", 64'(we_a[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset drops we", 64'(we_a[0]), 64'd0);
    check("reset drops we small", 64'(we_a[1]), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle();
    check("reset count", 64'(count_a[0]), 64'd0);
    log0.delete();
    req_i(3'd0, 5'd1, 5'd2, 16'h0004);
    idle(); idle();
    check("post-reset writes", 64'(log0.size()), 64'd1);
    if (log0.size() == 1) check("post-reset addr", 64'(log0[0].addr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
